// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path driven by a 16x-oversampled clken
// tick from the shared baud generator. The line goes through a two-flop
// synchronizer. Each bit is sampled at its mid-point. Every received byte is
// presented with a rdy flag, a clear handshake, and framing/overrun status.

module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       clken,
    input  logic       rdy_clr,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_COUNT = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] LAST_COUNT = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      bitpos;
    logic [7:0]      shift;
    logic            rx_meta;
    logic            rx_s;

    // Synchronize the line, run the frame FSM on clken ticks and keep the handshake status
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            count     <= '0;
            bitpos    <= 3'd0;
            shift     <= 8'h00;
            dout      <= 8'h00;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;

            if (rdy_clr) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end

            if (clken) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            count <= CW'(1);
                        end
                    end
                    START: begin
                        if (count == HALF_COUNT) begin
                            if (!rx_s) begin
                                state  <= DATA;
                                count  <= '0;
                                bitpos <= 3'd0;
                            end else begin
                                state <= IDLE;
                                count <= '0;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    DATA: begin
                        if (count == LAST_COUNT) begin
                            shift[bitpos] <= rx_s;
                            count         <= '0;
                            if (bitpos == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bitpos <= bitpos + 3'd1;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    STOP: begin
                        if (count == LAST_COUNT) begin
                            dout      <= shift;
                            rdy       <= 1'b1;
                            frame_err <= ~rx_s;
                            overrun   <= rdy;
                            count     <= '0;
                            state     <= IDLE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver. Frames are driven
// with 64 clk_50m cycles per bit (clken every 4 cycles, 16 ticks per bit).
// The expected delivery is queued before each frame is sent. A monitor pops
// the queue and compares whenever the receiver completes a full frame.

module tb_uart_receiver;

    localparam int BIT_CYCLES = 64;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       ov;
    } expect_t;

    logic       clk_50m;
    logic       rst_n;
    logic       rx;
    logic       clken;
    logic       rdy_clr;
    logic [7:0] dout;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    expect_t    exp_q[$];
    int         error_count;
    int         check_count;
    logic       saw_busy;

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .rx        (rx),
        .clken     (clken),
        .rdy_clr   (rdy_clr),
        .dout      (dout),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    // 50 MHz system clock
    initial begin
        clk_50m = 1'b0;
        forever #10 clk_50m = ~clk_50m;
    end

    // Oversample tick: one cycle high out of every four
    initial begin
        clken = 1'b0;
        forever begin
            repeat (3) @(negedge clk_50m);
            clken = 1'b1;
            @(negedge clk_50m);
            clken = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic holdLine(input logic level, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_50m);
            rx = level;
        end
    endtask

    // Drive one frame; clr_in_stop holds rdy_clr high exactly up to the delivery edge
    task automatic applyStimulus(input logic [7:0] data, input logic good_stop, input logic clr_in_stop);
        holdLine(1'b0, BIT_CYCLES);
        for (int b = 0; b < 8; b++) begin
            holdLine(data[b], BIT_CYCLES);
        end
        if (good_stop) begin
            for (int i = 0; i < BIT_CYCLES; i++) begin
                @(negedge clk_50m);
                rx = 1'b1;
                if (clr_in_stop) rdy_clr = rx_busy;
            end
            rdy_clr = 1'b0;
        end else begin
            holdLine(1'b0, 40);
            holdLine(1'b1, BIT_CYCLES - 40);
        end
        holdLine(1'b1, BIT_CYCLES * 2);
    endtask

    task automatic pushExpect(input logic [7:0] data, input logic fe, input logic ov);
        expect_t e;
        e.data = data;
        e.fe   = fe;
        e.ov   = ov;
        exp_q.push_back(e);
    endtask

    task automatic pulseClear();
        @(negedge clk_50m);
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
    endtask

    // Monitor: a full-length busy period ending marks a delivery to score
    initial begin
        logic    prev_busy;
        int      busy_len;
        expect_t e;
        prev_busy = 1'b0;
        busy_len  = 0;
        forever begin
            @(negedge clk_50m);
            if (rx_busy) begin
                busy_len++;
            end else if (prev_busy) begin
                if (busy_len >= 500) begin
                    if (exp_q.size() == 0) begin
                        check_count++;
                        error_count++;
                        $display("[TB] FAIL unexpectedDelivery: got dout 0x%02h, expected no delivery at %0t", dout, $time);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("deliverDout", dout, e.data);
                        checkOutput("deliverRdy", {7'd0, rdy}, 8'd1);
                        checkOutput("deliverFrameErr", {7'd0, frame_err}, {7'd0, e.fe});
                        checkOutput("deliverOverrun", {7'd0, overrun}, {7'd0, e.ov});
                    end
                end
                busy_len = 0;
            end
            prev_busy = rx_busy;
        end
    end

    // Main directed sequence
    initial begin
        error_count = 0;
        check_count = 0;
        rst_n   = 1'b0;
        rx      = 1'b1;
        rdy_clr = 1'b0;
        repeat (4) @(negedge clk_50m);
        rst_n = 1'b1;
        @(negedge clk_50m);
        checkOutput("resetDout", dout, 8'h00);
        checkOutput("resetRdy", {7'd0, rdy}, 8'd0);
        checkOutput("resetFrameErr", {7'd0, frame_err}, 8'd0);
        checkOutput("resetOverrun", {7'd0, overrun}, 8'd0);
        checkOutput("resetBusy", {7'd0, rx_busy}, 8'd0);
        holdLine(1'b1, 40);

        $display("[TB] good byte 0x55");
        pushExpect(8'h55, 1'b0, 1'b0);
        applyStimulus(8'h55, 1'b1, 1'b0);
        checkOutput("idleBusy55", {7'd0, rx_busy}, 8'd0);
        pulseClear();

        $display("[TB] start-bit glitch");
        saw_busy = 1'b0;
        holdLine(1'b0, 16);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_50m);
            rx = 1'b1;
            if (rx_busy) saw_busy = 1'b1;
        end
        checkOutput("glitchBusySeen", {7'd0, saw_busy}, 8'd1);
        checkOutput("glitchBusyEnd", {7'd0, rx_busy}, 8'd0);
        checkOutput("glitchRdy", {7'd0, rdy}, 8'd0);

        $display("[TB] bad stop 0xA3 then 0x0F");
        pushExpect(8'hA3, 1'b1, 1'b0);
        applyStimulus(8'hA3, 1'b0, 1'b0);
        pulseClear();
        @(negedge clk_50m);
        checkOutput("feHeldAfterClr", {7'd0, frame_err}, 8'd1);
        pushExpect(8'h0F, 1'b0, 1'b0);
        applyStimulus(8'h0F, 1'b1, 1'b0);
        pulseClear();

        $display("[TB] overrun 0x12 then 0x34");
        pushExpect(8'h12, 1'b0, 1'b0);
        applyStimulus(8'h12, 1'b1, 1'b0);
        pushExpect(8'h34, 1'b0, 1'b1);
        applyStimulus(8'h34, 1'b1, 1'b0);
        pulseClear();
        @(negedge clk_50m);
        checkOutput("clrRdy", {7'd0, rdy}, 8'd0);
        checkOutput("clrOverrun", {7'd0, overrun}, 8'd0);
        checkOutput("clrDoutHeld", dout, 8'h34);

        $display("[TB] rdy_clr on delivery edge 0xFF");
        pushExpect(8'hFF, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b1);
        checkOutput("sameEdgeRdyHeld", {7'd0, rdy}, 8'd1);
        pulseClear();

        $display("[TB] reset during 0xC3 bit 4");
        holdLine(1'b0, BIT_CYCLES);
        holdLine(1'b1, BIT_CYCLES * 2);
        holdLine(1'b0, BIT_CYCLES * 2);
        holdLine(1'b0, 32);
        @(negedge clk_50m);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk_50m);
        rst_n = 1'b1;
        checkOutput("midResetDout", dout, 8'h00);
        checkOutput("midResetRdy", {7'd0, rdy}, 8'd0);
        checkOutput("midResetBusy", {7'd0, rx_busy}, 8'd0);
        checkOutput("midResetOverrun", {7'd0, overrun}, 8'd0);
        holdLine(1'b1, BIT_CYCLES * 12);
        checkOutput("abandonedNoRdy", {7'd0, rdy}, 8'd0);
        pushExpect(8'h81, 1'b0, 1'b0);
        applyStimulus(8'h81, 1'b1, 1'b0);

        holdLine(1'b1, 100);
        checkOutput("scoreboardEmpty", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
